// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp patterns and lamp decode for the intersection controller.
package traffic_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        FL  = 3'd6
    } state_e;

    localparam logic [LAMP_W-1:0] L_G = 3'b100;
    localparam logic [LAMP_W-1:0] L_Y = 3'b010;
    localparam logic [LAMP_W-1:0] L_R = 3'b001;

    // Lamp pattern {main, side} for a state; f is the flash phase in FL.
    function automatic logic [2*LAMP_W-1:0] lamps(input state_e s, input logic f);
        logic [2*LAMP_W-1:0] l;
        case (s)
            MG:      l = {L_G, L_R};
            MY:      l = {L_Y, L_R};
            SG:      l = {L_R, L_G};
            SY:      l = {L_R, L_Y};
            FL:      l = {1'b0, f, 1'b0, 2'b00, f};
            default: l = {L_R, L_R};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer; cleared synchronously on reset or clr.
module phase_timer #(
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [TW-1:0] count
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != {TW{1'b1}}) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with all-red clearance, pedestrian walk and night flash.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TW           = 4,
    parameter int unsigned MIN_MAIN_GRN = 4,
    parameter int unsigned SIDE_GRN     = 3,
    parameter int unsigned MAX_SIDE_GRN = 6,
    parameter int unsigned YEL          = 2,
    parameter int unsigned ALLRED       = 1,
    parameter int unsigned FLASH_HALF   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 carew,
    input  logic                 ped_req,
    input  logic                 flash_en,
    output logic [2*LAMP_W-1:0]  lights,
    output logic                 walk,
    output logic [STATE_W-1:0]   state
);

    localparam logic [TW-1:0] T_MG    = TW'(MIN_MAIN_GRN - 1);
    localparam logic [TW-1:0] T_SG    = TW'(SIDE_GRN - 1);
    localparam logic [TW-1:0] T_SGMAX = TW'(MAX_SIDE_GRN - 1);
    localparam logic [TW-1:0] T_YEL   = TW'(YEL - 1);
    localparam logic [TW-1:0] T_AR    = TW'(ALLRED - 1);
    localparam logic [TW-1:0] T_FH    = TW'(FLASH_HALF - 1);

    state_e              state_q, state_d;
    logic                ped_pend_q, ped_pend_d;
    logic                flash_q, flash_d;
    logic [TW-1:0]       flash_cnt_q, flash_cnt_d;
    logic [2*LAMP_W-1:0] lights_q, lights_d;
    logic                walk_q, walk_d;
    logic                timer_clr;
    logic [TW-1:0]       timer;

    phase_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .count (timer)
    );

    always_comb begin
        state_d     = state_q;
        ped_pend_d  = ped_pend_q | ped_req;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        lights_d    = lights_q;
        walk_d      = 1'b0;
        timer_clr   = 1'b0;

        case (state_q)
            MG:  if (timer >= T_MG && (carew || ped_pend_q || flash_en)) state_d = MY;
            MY:  if (timer == T_YEL) state_d = AR1;
            AR1: if (timer == T_AR)  state_d = flash_en ? FL : SG;
            SG:  if (timer >= T_SG && (!carew || timer == T_SGMAX)) state_d = SY;
            SY:  if (timer == T_YEL) state_d = AR2;
            AR2: if (timer == T_AR)  state_d = flash_en ? FL : MG;
            FL:  if (!flash_en) state_d = AR2;
            default: state_d = MG;
        endcase

        timer_clr = (state_d != state_q);

        // Entering SG or FL serves any pending request, including one arriving this edge.
        if (timer_clr && (state_d == SG || state_d == FL)) begin
            ped_pend_d = 1'b0;
        end

        if (state_d == FL) begin
            if (state_q != FL) begin
                flash_d     = 1'b1;
                flash_cnt_d = '0;
            end else if (flash_cnt_q == T_FH) begin
                flash_d     = ~flash_q;
                flash_cnt_d = '0;
            end else begin
                flash_cnt_d = flash_cnt_q + TW'(1);
            end
        end

        lights_d = lamps(state_d, flash_d);
        walk_d   = (state_d == SG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MG;
            ped_pend_q  <= 1'b0;
            flash_q     <= 1'b0;
            flash_cnt_q <= '0;
            lights_q    <= {L_G, L_R};
            walk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ped_pend_q  <= ped_pend_d;
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
            lights_q    <= lights_d;
            walk_q      <= walk_d;
        end
    end

    assign lights = lights_q;
    assign walk   = walk_q;
    assign state  = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scenario bench for traffic_light_ctrl at default parameters.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       carew;
    logic       ped_req;
    logic       flash_en;
    logic [5:0] lights;
    logic       walk;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] P_MG  = 6'b100_001;
    localparam logic [5:0] P_MY  = 6'b010_001;
    localparam logic [5:0] P_AR  = 6'b001_001;
    localparam logic [5:0] P_SG  = 6'b001_100;
    localparam logic [5:0] P_SY  = 6'b001_010;
    localparam logic [5:0] P_OFF = 6'b000_000;

    traffic_light_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .carew    (carew),
        .ped_req  (ped_req),
        .flash_en (flash_en),
        .lights   (lights),
        .walk     (walk),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Number of consecutive cycles (from now) that lights hold pat; bounded.
    task automatic run_len(input logic [5:0] pat, output int n);
        n = 0;
        while (lights === pat && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; carew = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if (lights !== P_MG) begin failures++; $display("FAIL reset_lights got=%b exp=%b", lights, P_MG); end
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if (walk !== 1'b0) begin failures++; $display("FAIL reset_walk got=%b exp=0", walk); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (lights !== P_MG) begin failures++; $display("FAIL idle_mg cyc=%0d got=%b exp=%b", i, lights, P_MG); end
        end
    endtask

    task automatic test_single_car();
        logic [5:0] exp_seq [10];
        exp_seq = '{P_MY, P_MY, P_AR, P_SG, P_SG, P_SG, P_SY, P_SY, P_AR, P_MG};
        carew = 1'b1;
        step();
        carew = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            checks++;
            if (lights !== exp_seq[i]) begin failures++; $display("FAIL single_car cyc=%0d got=%b exp=%b", i, lights, exp_seq[i]); end
            checks++;
            if (walk !== (exp_seq[i] == P_SG)) begin failures++; $display("FAIL single_car_walk cyc=%0d got=%b exp=%b", i, walk, exp_seq[i] == P_SG); end
        end
    endtask

    task automatic test_car_stays();
        int n;
        carew = 1'b1;
        run_len(P_MG, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL car_stays_mg1 got=%0d exp=4", n); end
        run_len(P_MY, n);
        run_len(P_AR, n);
        run_len(P_SG, n);
        checks++;
        if (n != 6) begin failures++; $display("FAIL car_stays_sg got=%0d exp=6", n); end
        run_len(P_SY, n);
        run_len(P_AR, n);
        run_len(P_MG, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL car_stays_mg2 got=%0d exp=4", n); end
        carew = 1'b0;
        run_len(P_MY, n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL car_stays_my got=%0d exp=2", n); end
        run_len(P_AR, n);
        run_len(P_SG, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL car_gone_sg got=%0d exp=3", n); end
        run_len(P_SY, n);
        run_len(P_AR, n);
        checks++;
        if (lights !== P_MG) begin failures++; $display("FAIL car_stays_end got=%b exp=%b", lights, P_MG); end
    endtask

    task automatic test_early_car();
        carew = 1'b1;
        step();
        carew = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if (lights !== P_MG) begin failures++; $display("FAIL early_car cyc=%0d got=%b exp=%b", i, lights, P_MG); end
        end
    endtask

    task automatic test_ped();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (dut.ped_pend_q !== 1'b1) begin failures++; $display("FAIL ped_latched got=%b exp=1", dut.ped_pend_q); end
        run_len(P_MG, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL ped_mg_len got=%0d exp=3", n); end
        run_len(P_MY, n);
        run_len(P_AR, n);
        checks++;
        if (walk !== 1'b1) begin failures++; $display("FAIL ped_walk got=%b exp=1", walk); end
        checks++;
        if (state !== 3'd3) begin failures++; $display("FAIL ped_state_sg got=%0d exp=3", state); end
        checks++;
        if (dut.ped_pend_q !== 1'b0) begin failures++; $display("FAIL ped_cleared got=%b exp=0", dut.ped_pend_q); end
        run_len(P_SG, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL ped_sg_len got=%0d exp=3", n); end
        checks++;
        if (walk !== 1'b0) begin failures++; $display("FAIL ped_walk_off got=%b exp=0", walk); end
        run_len(P_SY, n);
        run_len(P_AR, n);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (lights !== P_MG) begin failures++; $display("FAIL ped_served cyc=%0d got=%b exp=%b", i, lights, P_MG); end
            step();
        end
    endtask

    task automatic test_clear_wins();
        int n;
        carew = 1'b1;
        step();
        carew = 1'b0;
        step();
        step();
        checks++;
        if (lights !== P_AR) begin failures++; $display("FAIL cw_ar1 got=%b exp=%b", lights, P_AR); end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (lights !== P_SG) begin failures++; $display("FAIL cw_sg got=%b exp=%b", lights, P_SG); end
        checks++;
        if (dut.ped_pend_q !== 1'b0) begin failures++; $display("FAIL cw_pend got=%b exp=0", dut.ped_pend_q); end
        run_len(P_SG, n);
        run_len(P_SY, n);
        run_len(P_AR, n);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (lights !== P_MG) begin failures++; $display("FAIL cw_mg_hold cyc=%0d got=%b exp=%b", i, lights, P_MG); end
            step();
        end
    endtask

    task automatic test_flash();
        logic [5:0] e;
        flash_en = 1'b1;
        step();
        checks++;
        if (lights !== P_MY) begin failures++; $display("FAIL fl_my got=%b exp=%b", lights, P_MY); end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (dut.ped_pend_q !== 1'b1) begin failures++; $display("FAIL fl_pend_set got=%b exp=1", dut.ped_pend_q); end
        step();
        checks++;
        if (lights !== P_AR) begin failures++; $display("FAIL fl_ar1 got=%b exp=%b", lights, P_AR); end
        step();
        checks++;
        if (state !== 3'd6) begin failures++; $display("FAIL fl_state got=%0d exp=6", state); end
        checks++;
        if (dut.ped_pend_q !== 1'b0) begin failures++; $display("FAIL fl_pend_clr got=%b exp=0", dut.ped_pend_q); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            e = (((k / 2) % 2) == 0) ? P_MY : P_OFF;
            checks++;
            if (lights !== e) begin failures++; $display("FAIL fl_blink cyc=%0d got=%b exp=%b", k, lights, e); end
            checks++;
            if (walk !== 1'b0) begin failures++; $display("FAIL fl_walk cyc=%0d got=%b exp=0", k, walk); end
        end
        flash_en = 1'b0;
        step();
        checks++;
        if (lights !== P_AR || state !== 3'd5) begin failures++; $display("FAIL fl_ar2 got=%b/%0d exp=%b/5", lights, state, P_AR); end
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (lights !== P_MG) begin failures++; $display("FAIL fl_back_mg cyc=%0d got=%b exp=%b", i, lights, P_MG); end
            step();
        end
    endtask

    task automatic test_reset_mid_sg();
        carew = 1'b1;
        step();
        carew = 1'b0;
        step();
        step();
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (walk !== 1'b1 || lights !== P_SG) begin failures++; $display("FAIL rmsg_pre got=%b/%b exp=1/%b", walk, lights, P_SG); end
        checks++;
        if (dut.ped_pend_q !== 1'b1) begin failures++; $display("FAIL rmsg_pend_pre got=%b exp=1", dut.ped_pend_q); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (lights !== P_MG) begin failures++; $display("FAIL rmsg_lights got=%b exp=%b", lights, P_MG); end
        checks++;
        if (walk !== 1'b0) begin failures++; $display("FAIL rmsg_walk got=%b exp=0", walk); end
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL rmsg_state got=%0d exp=0", state); end
        checks++;
        if (dut.ped_pend_q !== 1'b0) begin failures++; $display("FAIL rmsg_pend got=%b exp=0", dut.ped_pend_q); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (lights !== P_MG) begin failures++; $display("FAIL rmsg_hold cyc=%0d got=%b exp=%b", i, lights, P_MG); end
        end
    endtask

    initial begin
        test_reset();
        test_single_car();
        test_car_stays();
        test_early_car();
        test_ped();
        test_clear_wins();
        test_flash();
        test_reset_mid_sg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
